// File: rtl/shared_memory_copy_master.sv
// Avalon-MM word copy engine: reads one word, writes it back, repeats for len words.
// Unpipelined (one read outstanding); all outputs are registered, waitrequest holds the command.
module shared_memory_copy_master #(
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 33750
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    WR_CMD  = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // Range check width: one bit wider than the larger of address and length.
  localparam int CW = ((ADDR_W > 16) ? ADDR_W : 16) + 1;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [15:0]       cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              cs_q;
  logic              rd_q;
  logic              wr_q;
  logic [3:0]        be_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [CW-1:0] src_end;
  logic [CW-1:0] dst_end;
  logic [CW-1:0] depth_c;
  logic          range_err;

  assign src_end   = CW'(src_addr) + CW'(len);
  assign dst_end   = CW'(dst_addr) + CW'(len);
  assign depth_c   = CW'(MEM_DEPTH);
  assign range_err = (src_end > depth_c) || (dst_end > depth_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == 16'd0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else if (range_err) begin
              err_q <= 1'b1;
            end else begin
              src_q   <= src_addr;
              dst_q   <= dst_addr;
              cnt_q   <= len;
              addr_q  <= src_addr;
              cs_q    <= 1'b1;
              rd_q    <= 1'b1;
              be_q    <= 4'hF;
              busy_q  <= 1'b1;
              state_q <= RD_CMD;
            end
          end
        end
        RD_CMD: begin
          if (!avm_waitrequest) begin
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            be_q    <= 4'h0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            wdata_q <= avm_readdata;
            addr_q  <= dst_q;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            be_q    <= 4'hF;
            state_q <= WR_CMD;
          end
        end
        WR_CMD: begin
          if (!avm_waitrequest) begin
            src_q <= src_q + 1'b1;
            dst_q <= dst_q + 1'b1;
            cnt_q <= cnt_q - 16'd1;
            wr_q  <= 1'b0;
            if (cnt_q == 16'd1) begin
              cs_q    <= 1'b0;
              be_q    <= 4'h0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              // Next read issues straight out of the accepted write.
              addr_q  <= src_q + 1'b1;
              rd_q    <= 1'b1;
              state_q <= RD_CMD;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_shared_memory_copy_master.sv
// Bench for shared_memory_copy_master: Avalon memory model with scripted/random waitrequest,
// reference copy model on a shadow array, per-copy cycle accounting.
module tb_shared_memory_copy_master;

  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 33750;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_addr = 16'h0;
  logic [15:0] dst_addr = 16'h0;
  logic [15:0] len = 16'h0;
  logic        busy, done, error;
  logic [15:0] avm_address;
  logic        avm_chipselect, avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;

  always #5 clk = ~clk;

  shared_memory_copy_master #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .error(error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  int unsigned seed;
  int total = 0;
  int bad = 0;
  int test_no = 0;

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000 ^ seed;
  endfunction

  // Memory: writes on acceptance; read data returns two edges after acceptance.
  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:65535];
  bit          mem_init_done = 1'b0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_paddr = 16'h0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (avm_chipselect && avm_write && !avm_waitrequest) begin
      mem[avm_address] <= avm_writedata;
    end
    rd_pend           <= avm_chipselect && avm_read && !avm_waitrequest;
    rd_paddr          <= avm_address;
    avm_readdatavalid <= rd_pend;
    avm_readdata      <= rd_pend ? mem[rd_paddr] : 32'h0;
  end

  // Monitor: samples mid-cycle, then sets this cycle's waitrequest from the per-command stall script.
  int rd_stall [64];
  int wr_stall [64];
  int cyc = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, cs_cnt = 0, proto_err = 0;
  int start_cyc = 0, pulse_cyc = 0, rd_idx = 0, wr_idx = 0, rem = 0;
  bit prev_stall = 1'b0;
  logic [15:0] s_addr;
  logic [31:0] s_wd;
  logic s_rd, s_wr;

  always @(negedge clk) begin
    bit w;
    cyc++;
    if (prev_stall && (avm_address !== s_addr || avm_writedata !== s_wd ||
        avm_read !== s_rd || avm_write !== s_wr || avm_chipselect !== 1'b1)) proto_err++;
    if (avm_read && avm_write) proto_err++;
    if ((avm_read || avm_write) && !avm_chipselect) proto_err++;
    if (avm_byteenable !== (avm_chipselect ? 4'hF : 4'h0)) proto_err++;
    if (avm_chipselect) cs_cnt++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; pulse_cyc = cyc; end
    if (error) begin err_cnt++; pulse_cyc = cyc; end
    if (start && !busy) begin start_cyc = cyc; rd_idx = 0; wr_idx = 0; rem = 0; end
    if (!prev_stall && avm_read) begin rem = rd_stall[rd_idx % 64]; rd_idx++; end
    if (!prev_stall && avm_write) begin rem = wr_stall[wr_idx % 64]; wr_idx++; end
    w = (avm_read || avm_write) && (rem > 0);
    if (w) rem--;
    avm_waitrequest = w;
    prev_stall = w;
    s_addr = avm_address; s_wd = avm_writedata; s_rd = avm_read; s_wr = avm_write;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s (test %0d): observed=%0h expected=%0h", tag, test_no, obs, exp);
    end
  endtask

  task automatic check_mem();
    int mism = 0;
    int first = -1;
    for (int i = 0; i < 65536; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    if (mism != 0) $display("first differing word at %0h", first);
    check("mem_contents", 64'(mism), 64'd0);
  endtask

  task automatic set_stalls(input int maxw);
    for (int i = 0; i < 64; i++) begin
      rd_stall[i] = (maxw == 0) ? 0 : int'($urandom_range(0, maxw));
      wr_stall[i] = (maxw == 0) ? 0 : int'($urandom_range(0, maxw));
    end
  endtask

  task automatic run_copy(input int s, input int d, input int n, input bit poke);
    int d0, e0, b0, c0, p0, exp_stall;
    bit oob, seen;
    test_no++;
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt; c0 = cs_cnt; p0 = proto_err;
    exp_stall = 0;
    seen = 1'b0;
    oob = (n != 0) && ((s + n > MEM_DEPTH) || (d + n > MEM_DEPTH));
    if (!oob) begin
      for (int i = 0; i < n; i++) begin
        exp_stall += rd_stall[i] + wr_stall[i];
        ref_mem[(d + i) % 65536] = ref_mem[(s + i) % 65536];
      end
    end
    @(posedge clk); #1;
    start = 1'b1; src_addr = 16'(s); dst_addr = 16'(d); len = 16'(n);
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      start = poke && (i == 5);
      if (start) begin src_addr = 16'h0; dst_addr = 16'h0020; len = 16'd1; end
      seen = (done_cnt != d0) || (err_cnt != e0);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("completion_seen", 64'(seen), 64'd1);
    check("done_pulses", 64'(done_cnt - d0), oob ? 64'd0 : 64'd1);
    check("error_pulses", 64'(err_cnt - e0), oob ? 64'd1 : 64'd0);
    check("busy_cycles", 64'(busy_cnt - b0), oob ? 64'd0 : 64'(4 * n + exp_stall));
    check("chipselect_cycles", 64'(cs_cnt - c0), oob ? 64'd0 : 64'(2 * n + exp_stall));
    check("bus_protocol", 64'(proto_err - p0), 64'd0);
    if (n == 0 || oob) check("pulse_latency", 64'(pulse_cyc - start_cyc), 64'd1);
    check_mem();
  endtask

  initial begin
    int d0;
    bit found;
    seed = $urandom;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    set_stalls(0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, done, error, avm_chipselect, avm_read, avm_write,
          avm_byteenable, avm_address, avm_writedata}), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_copy(16'h0010, 16'h0100, 4, 1'b0);
    run_copy(16'h0020, 16'h0030, 0, 1'b0);
    run_copy(33740, 16'h0050, 11, 1'b0);
    run_copy(16'h0010, 33745, 6, 1'b0);
    run_copy(33740, 16'h0060, 10, 1'b0);

    set_stalls(0);
    rd_stall[1] = 3;
    wr_stall[0] = 2;
    run_copy(16'h0200, 16'h0210, 4, 1'b0);

    set_stalls(0);
    run_copy(16'h0040, 16'h0042, 5, 1'b1);

    test_no++;
    d0 = done_cnt;
    found = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; src_addr = 16'h0300; dst_addr = 16'h0400; len = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      found = avm_write && (wr_idx == 2);
    end
    check("reach_second_write", 64'(found), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 64'({busy, done, error, avm_chipselect, avm_read, avm_write,
          avm_byteenable, avm_address, avm_writedata}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    ref_mem[16'h0400] = ref_mem[16'h0300];
    check_mem();
    run_copy(16'h0500, 16'h0510, 2, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int s, d, n;
      s = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      n = int'($urandom_range(0, 10));
      set_stalls(2);
      run_copy(s, d, n, (t % 2 == 1) && (n >= 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
